cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Schedules the shared Common Data Bus among functional units (FUs) completing results.
- Each cycle, grants at most CDB_W of NUM_REQ requesters with round-robin fairness.
- Registers the winners onto the CDB, which feeds the reservation station wakeup, ROB completion and map table.
- Losing FUs are back-pressured and hold their result until granted.

Parameters:
NUM_REQ, 8, number of FU completion requesters (ALU+MULT+LOAD+STORE ports)
CDB_W, `N, number of CDB broadcast slots per cycle
TAG_W, 6, physical register tag width
DATA_W, 32, result value width

Ports:
clock  input  1  system clock
reset  input  1  synchronous active-high reset
squash  input  1  pipeline flush; kills grants and CDB contents
req_valid  input  NUM_REQ  FU i has a completed result
req_tag  input  NUM_REQ x TAG_W  destination tag per requester
req_value  input  NUM_REQ x DATA_W  result value per requester
req_gnt  output  NUM_REQ  combinational grant; FU i result accepted this cycle
cdb_valid  output  CDB_W  registered broadcast slot valid
cdb_tag  output  CDB_W x TAG_W  registered broadcast tag
cdb_value  output  CDB_W x DATA_W  registered broadcast value
congested  output  1  registered; last cycle had more valid requests than CDB_W

Behaviour:
- Reset values (synchronous, active-high): all outputs are 0; the priority pointer ptr is 0.
- Grant selection (combinational, cycle t):
  - Scan requesters starting at index ptr, ascending, wrapping modulo NUM_REQ.
  - The first min(CDB_W, popcount(req_valid)) valid requesters get req_gnt=1.
  - req_gnt is never asserted for a requester with req_valid=0.
  - At most CDB_W grant bits are set.
- Slot mapping: the k-th granted requester in scan order drives CDB slot k. Unused slots have cdb_valid=0. Tag and value of unused slots are don't-care, but the bench expects 0.
- Latency: a grant in cycle t appears on cdb_* at cycle t+1, lasting exactly one cycle.
- Pointer update at posedge:
  - If any grant occurs, ptr becomes (index of last granted requester + 1) mod NUM_REQ.
  - Otherwise ptr is unchanged.
- Handshake:
  - A requester holds req_valid, req_tag and req_value stable until it sees req_gnt=1.
  - It may present a new result in the cycle after the grant.
  - Changing a pending request before grant is illegal; the bench asserts this.
- Starvation bound: a continuously valid requester is granted within ceil(NUM_REQ/CDB_W) cycles.
- congested: registered as (popcount(req_valid) > CDB_W), evaluated in the same cycle as the grant.
- Squash:
  - While squash=1, req_gnt=0 for all requesters.
  - At the next posedge, cdb_valid is cleared, ptr is reset to 0 and congested is cleared.
  - Requesters are expected to drop req_valid on squash.
- Reset mid-operation: same clearing as squash. Any in-flight cdb_valid is dropped at the reset posedge.
- Simultaneous reset and squash: reset dominates, with an identical result.
- Duplicate tags across requesters are not checked; the arbiter passes them through.
- Widths: popcount and ptr are $clog2(NUM_REQ)+1 bits. Wrap is computed modulo NUM_REQ; no overflow.

Test Plan:
- Reset with all req_valid=1 → cycle after reset: cdb_valid=0, congested=0. First grant is {0,1} for CDB_W=2, NUM_REQ=8.
- Single request req_valid=8'b0001_0000, tag=6'd17, value=32'hDEAD_BEEF → req_gnt[4]=1 same cycle. Next cycle: cdb_valid=2'b01, cdb_tag[0]=17, cdb_value[0]=DEAD_BEEF; ptr=5.
- All 8 requesters valid continuously, CDB_W=2 → grants rotate {0,1},{2,3},{4,5},{6,7},{0,1}. congested=1 every cycle; no requester waits more than 4 cycles.
- Wrap case: ptr=7, req_valid=8'b1000_0001 → both granted. Slot0 carries requester 7, slot1 carries requester 0; new ptr=1.
- Back-pressure: requester 3 valid but not granted for 2 cycles with unchanged tag/value. Its grant cycle is followed by exactly one broadcast of that tag, never duplicated.
- Squash with 5 pending requests → req_gnt=0 that cycle. Next cycle: cdb_valid=0, congested=0; the following arbitration starts at index 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants up to CDB_W of NUM_REQ completing FUs per cycle
// in round-robin order and registers the winners onto the broadcast slots.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned CDB_W   = 2,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              squash,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_value,
  output logic [NUM_REQ-1:0]                req_gnt,
  output logic [CDB_W-1:0]                  cdb_valid,
  output logic [CDB_W-1:0][TAG_W-1:0]       cdb_tag,
  output logic [CDB_W-1:0][DATA_W-1:0]      cdb_value,
  output logic                              congested
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ) + 1;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SLT_W = (CDB_W > 1) ? $clog2(CDB_W) : 1;

  logic [PTR_W-1:0]               r_ptr;
  logic [PTR_W-1:0]               w_ptr_nxt;
  logic [PTR_W-1:0]               w_pop;
  logic [CDB_W-1:0]               w_slot_vld;
  logic [CDB_W-1:0][TAG_W-1:0]    w_slot_tag;
  logic [CDB_W-1:0][DATA_W-1:0]   w_slot_value;

  // Number of valid requesters, used only for the congestion flag.
  always_comb begin : pop_count
    w_pop = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_pop = w_pop + PTR_W'(req_valid[k]);
    end
  end

  // Rotating scan from r_ptr; the k-th winner in scan order lands in slot k.
  always_comb begin : grant_scan
    int unsigned idx;
    int unsigned cnt;
    idx          = 0;
    cnt          = 0;
    req_gnt      = '0;
    w_slot_vld   = '0;
    w_slot_tag   = '0;
    w_slot_value = '0;
    w_ptr_nxt    = r_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(r_ptr) + k) % NUM_REQ;
      if (!reset && !squash && req_valid[IDX_W'(idx)] && (cnt < CDB_W)) begin
        req_gnt[IDX_W'(idx)]      = 1'b1;
        w_slot_vld[SLT_W'(cnt)]   = 1'b1;
        w_slot_tag[SLT_W'(cnt)]   = req_tag[IDX_W'(idx)];
        w_slot_value[SLT_W'(cnt)] = req_value[IDX_W'(idx)];
        w_ptr_nxt                 = PTR_W'((idx + 1) % NUM_REQ);
        cnt                       = cnt + 1;
      end
    end
  end

  // Broadcast registers; squash clears exactly like reset.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      r_ptr     <= '0;
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      congested <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      cdb_valid <= w_slot_vld;
      cdb_tag   <= w_slot_tag;
      cdb_value <= w_slot_value;
      congested <= (32'(w_pop) > CDB_W);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_REQ=8, CDB_W=2): vector table plus
// hand-written squash, back-pressure and reset sequences.
module tb_cdb_arbiter;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned CDB_W   = 2;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NVEC    = 16;

  logic                           clock;
  logic                           reset;
  logic                           squash;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_value;
  logic [NUM_REQ-1:0]             req_gnt;
  logic [CDB_W-1:0]               cdb_valid;
  logic [CDB_W-1:0][TAG_W-1:0]    cdb_tag;
  logic [CDB_W-1:0][DATA_W-1:0]   cdb_value;
  logic                           congested;

  int checks   = 0;
  int failures = 0;

  logic [NUM_REQ-1:0]             prev_pend = '0;
  logic [NUM_REQ-1:0][TAG_W-1:0]  prev_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] prev_value;

  typedef struct {
    logic [7:0] valid;
    logic [7:0] gnt;
    logic [1:0] cvld;
    int         s0;
    int         s1;
    logic       cong;
  } vec_t;

  vec_t vecs [NVEC];

  cdb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CDB_W   (CDB_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_value (req_value),
    .req_gnt   (req_gnt),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .congested (congested)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [TAG_W-1:0] dtag(input int i);
    return TAG_W'(i + 40);
  endfunction

  function automatic logic [DATA_W-1:0] dval(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then verify the requester hold protocol.
  task automatic drive(input logic rst, input logic sq, input logic [7:0] v);
    reset     = rst;
    squash    = sq;
    req_valid = v;
    #1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (prev_pend[i])
        check($sformatf("hold%0d", i), {31'd0, req_valid[i], req_tag[i], req_value[i]},
              {31'd0, 1'b1, prev_tag[i], prev_value[i]});
    end
    prev_pend  = (rst || sq) ? '0 : (req_valid & ~req_gnt);
    prev_tag   = req_tag;
    prev_value = req_value;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_cdb(input string n, input logic [1:0] vld, input int s0, input int s1,
                           input logic cong);
    check({n, "_vld"},  64'(cdb_valid),    64'(vld));
    check({n, "_tag0"}, 64'(cdb_tag[0]),   vld[0] ? 64'(dtag(s0)) : 64'd0);
    check({n, "_val0"}, 64'(cdb_value[0]), vld[0] ? 64'(dval(s0)) : 64'd0);
    check({n, "_tag1"}, 64'(cdb_tag[1]),   vld[1] ? 64'(dtag(s1)) : 64'd0);
    check({n, "_val1"}, 64'(cdb_value[1]), vld[1] ? 64'(dval(s1)) : 64'd0);
    check({n, "_cong"}, 64'(congested),    64'(cong));
  endtask

  initial begin
    vecs[0]  = '{8'hFF, 8'h03, 2'b11, 0, 1, 1'b1};
    vecs[1]  = '{8'hFF, 8'h0C, 2'b11, 2, 3, 1'b1};
    vecs[2]  = '{8'hFF, 8'h30, 2'b11, 4, 5, 1'b1};
    vecs[3]  = '{8'hFF, 8'hC0, 2'b11, 6, 7, 1'b1};
    vecs[4]  = '{8'hFF, 8'h03, 2'b11, 0, 1, 1'b1};
    vecs[5]  = '{8'hFF, 8'h0C, 2'b11, 2, 3, 1'b1};
    vecs[6]  = '{8'hF3, 8'h30, 2'b11, 4, 5, 1'b1};
    vecs[7]  = '{8'hC3, 8'hC0, 2'b11, 6, 7, 1'b1};
    vecs[8]  = '{8'h03, 8'h03, 2'b11, 0, 1, 1'b0};
    vecs[9]  = '{8'h10, 8'h10, 2'b01, 4, 0, 1'b0};
    vecs[10] = '{8'h00, 8'h00, 2'b00, 0, 0, 1'b0};
    vecs[11] = '{8'h21, 8'h21, 2'b11, 5, 0, 1'b0};
    vecs[12] = '{8'h0E, 8'h06, 2'b11, 1, 2, 1'b1};
    vecs[13] = '{8'h08, 8'h08, 2'b01, 3, 0, 1'b0};
    vecs[14] = '{8'h40, 8'h40, 2'b01, 6, 0, 1'b0};
    vecs[15] = '{8'h81, 8'h81, 2'b11, 7, 0, 1'b0};

    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_tag[i]   = dtag(i);
      req_value[i] = dval(i);
    end
    prev_tag   = req_tag;
    prev_value = req_value;

    // Reset with every requester asking
    drive(1'b1, 1'b0, 8'hFF);
    tick;
    check_cdb("rst", 2'b00, 0, 0, 1'b0);

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(1'b0, 1'b0, vecs[i].valid);
      check($sformatf("v%0d_gnt", i), 64'(req_gnt), 64'(vecs[i].gnt));
      tick;
      check_cdb($sformatf("v%0d", i), vecs[i].cvld, vecs[i].s0, vecs[i].s1, vecs[i].cong);
    end

    // Squash with five pending requests; pointer must restart at 0
    drive(1'b0, 1'b0, 8'h20);
    check("sq_pre_gnt", 64'(req_gnt), 64'h20);
    tick;
    check_cdb("sq_pre", 2'b01, 5, 0, 1'b0);
    drive(1'b0, 1'b1, 8'h1F);
    check("sq_gnt", 64'(req_gnt), 64'h00);
    tick;
    check_cdb("sq_post", 2'b00, 0, 0, 1'b0);
    drive(1'b0, 1'b0, 8'h81);
    check("sq_next_gnt", 64'(req_gnt), 64'h81);
    tick;
    check_cdb("sq_next", 2'b11, 0, 7, 1'b0);

    // Single request with a specific tag/value
    req_tag[4]   = 6'd17;
    req_value[4] = 32'hDEAD_BEEF;
    drive(1'b0, 1'b0, 8'h10);
    check("one_gnt", 64'(req_gnt), 64'h10);
    tick;
    check("one_vld",  64'(cdb_valid),    64'h1);
    check("one_tag0", 64'(cdb_tag[0]),   64'd17);
    check("one_val0", 64'(cdb_value[0]), 64'hDEAD_BEEF);
    check("one_tag1", 64'(cdb_tag[1]),   64'd0);
    req_tag[4]   = dtag(4);
    req_value[4] = dval(4);
    drive(1'b0, 1'b0, 8'h28);
    check("ptr5_gnt", 64'(req_gnt), 64'h28);
    tick;
    check_cdb("ptr5", 2'b11, 5, 3, 1'b0);

    // Requester 3 back-pressured for two cycles, then broadcast exactly once
    drive(1'b0, 1'b0, 8'hF8);
    check("bp0_gnt", 64'(req_gnt), 64'h30);
    tick;
    check_cdb("bp0", 2'b11, 4, 5, 1'b1);
    drive(1'b0, 1'b0, 8'hC8);
    check("bp1_gnt", 64'(req_gnt), 64'hC0);
    tick;
    check_cdb("bp1", 2'b11, 6, 7, 1'b1);
    drive(1'b0, 1'b0, 8'h08);
    check("bp2_gnt", 64'(req_gnt), 64'h08);
    tick;
    check_cdb("bp2", 2'b01, 3, 0, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    check("bp3_gnt", 64'(req_gnt), 64'h00);
    tick;
    check_cdb("bp3", 2'b00, 0, 0, 1'b0);

    // Reset in the middle of traffic drops the in-flight broadcast
    drive(1'b0, 1'b0, 8'hFF);
    check("mr0_gnt", 64'(req_gnt), 64'h30);
    tick;
    drive(1'b1, 1'b0, 8'hFF);
    tick;
    check_cdb("mr1", 2'b00, 0, 0, 1'b0);
    drive(1'b0, 1'b0, 8'hFF);
    check("mr2_gnt", 64'(req_gnt), 64'h03);
    tick;
    check_cdb("mr2", 2'b11, 0, 1, 1'b1);

    // Reset and squash together behave like reset
    drive(1'b1, 1'b1, 8'hFF);
    tick;
    check_cdb("rs0", 2'b00, 0, 0, 1'b0);
    drive(1'b0, 1'b0, 8'h82);
    check("rs1_gnt", 64'(req_gnt), 64'h82);
    tick;
    check_cdb("rs1", 2'b11, 1, 7, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    tick;
    check_cdb("rs2", 2'b00, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
